// File: rtl/rand_display_pkg.sv
// Shared types and constants for the random-sample display block:
// debouncer state encoding and active-low hex segment patterns {g,f,e,d,c,b,a}.
package rand_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        HELD,
        WAIT_RELEASE
    } db_state_t;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Index 0 is the rightmost entry; b and d use lowercase glyphs.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        SEG_ZERO     // 0
    };

endpackage

// File: rtl/rand_display_hex7seg.sv
// Hex digit to active-low 7-segment decoder.
// Ports: hex (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a}, active-low).
module hex7seg
    import rand_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/rand_display.sv
// Captures the upstream random byte on a debounced button press or a periodic
// auto tick, counts captures and shows sample/count on four hex displays.
// Ports: clk, rst_n, random[8], btn, sw_auto -> sample[8], sample_valid,
//        count[8], seg_lo/seg_hi (sample), seg_cnt_lo/seg_cnt_hi (count).
module rand_display
    import rand_display_pkg::*;
#(
    parameter int DB_CYCLES   = 50000,
    parameter int AUTO_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] random,
    input  logic       btn,
    input  logic       sw_auto,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [7:0] count,
    output logic [6:0] seg_lo,
    output logic [6:0] seg_hi,
    output logic [6:0] seg_cnt_lo,
    output logic [6:0] seg_cnt_hi
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [AP_W-1:0] AP_MAX = AP_W'(AUTO_PERIOD - 1);

    logic btn_q1, btn_s;
    logic auto_q1, auto_s;

    db_state_t       state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [AP_W-1:0] per_cnt;
    logic            press, auto_evt, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q1  <= 1'b0;
            btn_s   <= 1'b0;
            auto_q1 <= 1'b0;
            auto_s  <= 1'b0;
        end else begin
            btn_q1  <= btn;
            btn_s   <= btn_q1;
            auto_q1 <= sw_auto;
            auto_s  <= auto_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Only the WAIT_PRESS -> HELD edge raises an event, so a long hold or a
    // bounce on release can never produce a second capture.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        press    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = WAIT_PRESS;
                    db_cnt_d = '0;
                end
            end
            WAIT_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d = HELD;
                    press   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d  = WAIT_RELEASE;
                    db_cnt_d = '0;
                end
            end
            WAIT_RELEASE: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_MAX) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
        end else if (!auto_s || per_cnt == AP_MAX) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    assign auto_evt = auto_s && (per_cnt == AP_MAX);
    assign capture  = press | auto_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= 8'h00;
            count        <= 8'h00;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                sample <= random;
                count  <= count + 8'd1;
            end
        end
    end

    hex7seg u_seg_lo     (.hex(sample[3:0]), .seg(seg_lo));
    hex7seg u_seg_hi     (.hex(sample[7:4]), .seg(seg_hi));
    hex7seg u_seg_cnt_lo (.hex(count[3:0]),  .seg(seg_cnt_lo));
    hex7seg u_seg_cnt_hi (.hex(count[7:4]),  .seg(seg_cnt_hi));

endmodule

// File: tb/tb_rand_display.sv
// Scoreboard bench for rand_display with DB_CYCLES=4, AUTO_PERIOD=8.
// Stimulus pushes expected captures (value, count, cycle); a monitor checks them.
module tb_rand_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] random;
    logic       btn;
    logic       sw_auto;
    logic [7:0] sample;
    logic       sample_valid;
    logic [7:0] count;
    logic [6:0] seg_lo, seg_hi, seg_cnt_lo, seg_cnt_hi;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        int         cy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k;

    rand_display #(.DB_CYCLES(4), .AUTO_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .random(random), .btn(btn),
        .sw_auto(sw_auto), .sample(sample), .sample_valid(sample_valid),
        .count(count), .seg_lo(seg_lo), .seg_hi(seg_hi),
        .seg_cnt_lo(seg_cnt_lo), .seg_cnt_hi(seg_cnt_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0: r = 7'b1000000; 4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100; 4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001; 4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010; 4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000; 4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000; 4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110; 4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110; default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] c, input int cy);
        exp_t e;
        e.s  = s;
        e.c  = c;
        e.cy = cy;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_capture: got count %h at cycle %0d want none",
                         count, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chki("capture_cycle", cyc, e.cy);
                chk("sample", sample, e.s);
                chk("count", count, e.c);
                chk("seg_lo", {1'b0, seg_lo}, {1'b0, seg_of(e.s[3:0])});
                chk("seg_hi", {1'b0, seg_hi}, {1'b0, seg_of(e.s[7:4])});
                chk("seg_cnt_lo", {1'b0, seg_cnt_lo}, {1'b0, seg_of(e.c[3:0])});
                chk("seg_cnt_hi", {1'b0, seg_cnt_hi}, {1'b0, seg_of(e.c[7:4])});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        random  = 8'h00;
        btn     = 1'b0;
        sw_auto = 1'b0;
        tick(3);
        chk("rst_sample", sample, 8'h00);
        chk("rst_count", count, 8'h00);
        chk("rst_valid", {7'b0, sample_valid}, 8'h00);
        chk("rst_seg_lo", {1'b0, seg_lo}, 8'h40);
        chk("rst_seg_hi", {1'b0, seg_hi}, 8'h40);
        chk("rst_seg_cnt_lo", {1'b0, seg_cnt_lo}, 8'h40);
        chk("rst_seg_cnt_hi", {1'b0, seg_cnt_hi}, 8'h40);
        rst_n = 1'b1;
        tick(3);

        // clean press: capture 6 edges after the edge that first sees btn
        random = 8'hB4;
        k = cyc;
        btn = 1'b1;
        push(8'hB4, 8'h01, k + 7);
        tick(20);
        btn = 1'b0;
        tick(10);
        chk("press_sample", sample, 8'hB4);
        chk("press_seg_hi_b", {1'b0, seg_hi}, 8'h03);
        chk("press_seg_lo_4", {1'b0, seg_lo}, 8'h19);
        chk("press_count", count, 8'h01);

        // bounce: never stable for 4 cycles
        random = 8'h99;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            tick(2);
            btn = 1'b0;
            tick(2);
        end
        tick(12);
        chk("bounce_count", count, 8'h01);
        chk("bounce_sample", sample, 8'hB4);

        // auto mode: first tick 10 edges after enable, then every 8
        random = 8'h6C;
        k = cyc;
        sw_auto = 1'b1;
        for (int i = 0; i < 4; i++)
            push(8'h6C, 8'(2 + i), k + 10 + 8 * i);
        tick(36);
        sw_auto = 1'b0;
        tick(12);
        chk("auto_count", count, 8'h05);

        // preload to FF via auto, then press and auto land on the same edge
        random = 8'h3C;
        k = cyc;
        sw_auto = 1'b1;
        for (int i = 0; i < 250; i++)
            push(8'h3C, 8'(6 + i), k + 10 + 8 * i);
        tick(2003);
        btn = 1'b1;
        push(8'h3C, 8'h00, k + 2010);
        tick(7);
        sw_auto = 1'b0;
        tick(10);
        btn = 1'b0;
        tick(20);
        chk("wrap_count", count, 8'h00);

        // reset two cycles into WAIT_PRESS, button still held on release
        random = 8'h5A;
        btn = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_count", count, 8'h00);
        chk("midrst_sample", sample, 8'h00);
        chk("midrst_valid", {7'b0, sample_valid}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        k = cyc;
        push(8'h5A, 8'h01, k + 7);
        tick(15);
        btn = 1'b0;
        tick(10);
        chk("post_rst_count", count, 8'h01);

        chki("pending_captures", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rand_display.md
RAND_DISPLAY -- requirements
Module: rand_display

Interface
REQ-001 Parameter: DB_CYCLES, 50000, number of consecutive stable cycles a synchronized button level must hold to be accepted.
REQ-002 Parameter: AUTO_PERIOD, 25000000, cycles between captures in auto mode.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port: random  input  8  free-running pseudo-random value from the upstream LFSR, sampled as-is.
REQ-006 Port: btn  input  1  raw asynchronous push-button, active-high, bouncy.
REQ-007 Port: sw_auto  input  1  raw asynchronous slide switch; high selects periodic auto-capture.
REQ-008 Port: sample  output  8  last captured random value.
REQ-009 Port: sample_valid  output  1  one-cycle pulse marking a capture.
REQ-010 Port: count  output  8  number of captures since reset, modulo 256.
REQ-011 Port: seg_lo, seg_hi  output  7 each  active-low hex segments {g,f,e,d,c,b,a} for sample[3:0] and sample[7:4].
REQ-012 Port: seg_cnt_lo, seg_cnt_hi  output  7 each  active-low hex segments for count[3:0] and count[7:4].

Function
REQ-013 btn and sw_auto SHALL each pass through a 2-flop synchronizer before any use; btn_s and auto_s denote the synchronized levels.
REQ-014 The debouncer SHALL be a 4-state FSM: IDLE, WAIT_PRESS, HELD, WAIT_RELEASE.
REQ-015 IDLE -> WAIT_PRESS when btn_s=1; the stability counter clears on entry.
REQ-016 WAIT_PRESS: counter increments each cycle btn_s=1; btn_s=0 -> IDLE; counter reaching DB_CYCLES-1 with btn_s=1 -> HELD and one press event is raised.
REQ-017 HELD: stays while btn_s=1; btn_s=0 -> WAIT_RELEASE with counter cleared.
REQ-018 WAIT_RELEASE: counter increments each cycle btn_s=0; btn_s=1 -> HELD; counter reaching DB_CYCLES-1 -> IDLE; no event is raised on release.
REQ-019 Holding the button for any length of time SHALL produce exactly one press event.
REQ-020 In auto mode (auto_s=1) a period counter SHALL count 0..AUTO_PERIOD-1 and raise one auto event on the cycle it wraps; when auto_s=0 it is held at 0.
REQ-021 A capture occurs on a cycle with a press event, an auto event, or both; simultaneous events SHALL yield a single capture.
REQ-022 On a capture edge: sample <= random, count <= count+1 (255 wraps to 0), and sample_valid is 1 for that cycle only.
REQ-023 Segment outputs SHALL be combinational decodes of the registered sample and count, valid in the same cycle those registers update.
REQ-024 The hex decode SHALL cover 0-9 and A-F, with b and d in lowercase form.
REQ-025 Latency: a clean btn rising edge SHALL produce sample_valid exactly 2+DB_CYCLES cycles later.

Reset
REQ-026 While rst_n=0 the following SHALL hold: sample=8'h00, count=8'h00, sample_valid=0, FSM=IDLE, all counters and synchronizer flops=0, and all four seg outputs=7'b1000000 ("0").
REQ-027 Reset asserted mid-debounce or mid-period SHALL abandon the operation without a capture.
REQ-028 After rst_n deasserts, a btn already held high SHALL be treated as a new press.

Structure
REQ-029 A shared package rand_display_pkg SHALL hold the FSM state typedef, the segment-pattern constant table, and the 7'b1000000 blank/zero constant.
REQ-030 Counter widths SHALL be derived from the parameters via $clog2.
REQ-031 One sub-module, hex7seg (4-bit in, 7-bit active-low out), SHALL be instantiated four times.

Verification (DB_CYCLES=4, AUTO_PERIOD=8)
REQ-032 Reset: hold rst_n=0 -> sample=00, count=00, all segs=1000000, sample_valid=0.
REQ-033 Clean press: random held at 8'hB4 and btn high for 20 cycles -> one sample_valid pulse 6 cycles after the btn edge, sample=B4, seg_hi=b pattern (7'b0000011), seg_lo=4 pattern (7'b0011001), count=01.
REQ-034 Bounce: btn toggles 1/0 every 2 cycles for 20 cycles, then stays low -> no capture, count unchanged.
REQ-035 Auto mode: sw_auto=1 for 40 cycles -> sample_valid pulses spaced exactly 8 cycles apart, count increments once per pulse.
REQ-036 Collision and wrap: preload count to FF via 255 captures, then force a press event and an auto event in the same cycle -> single pulse, count=00.
REQ-037 Reset mid-debounce: assert rst_n=0 two cycles into WAIT_PRESS -> no capture; a press after release of reset captures normally.
